// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM states and helpers for the serial ALU
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_BEQ) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// rtl/serial_alu_seq_if.sv - operation request / result handshake bundle
interface serial_alu_seq_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [2:0]        op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              cout;
  logic              overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, cout, overflow
  );

endinterface

// File: rtl/alu_bit_slice.sv
// rtl/alu_bit_slice.sv - combinational 1-bit ALU slice: full adder with B-invert mux
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [2:0] op_i,
  output logic       y_o,
  output logic       cout_o
);

  logic b_eff;
  logic sum;

  // op[2] selects subtract-style ops; together with the preloaded carry this forms a - b
  assign b_eff  = op_i[2] ? ~b_i : b_i;
  assign sum    = a_i ^ b_eff ^ cin_i;
  assign cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));

  always_comb begin
    y_o = 1'b0;
    case (op_i)
      OP_AND:                         y_o = a_i & b_i;
      OP_OR:                          y_o = a_i | b_i;
      OP_ADD, OP_BEQ, OP_SUB, OP_SLT: y_o = sum;
      default:                        y_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - 32-bit bit-serial ALU sequencer, LSB first, one bit per clock
module serial_alu_seq
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  serial_alu_seq_if.slave bus
);

  state_t state_q, state_d;

  logic [DATA_W-1:0] a_q, b_q, sh_q, result_q;
  logic [2:0]        op_q;
  logic [4:0]        cnt_q;
  logic              carry_q, c31_q, fin_q;
  logic              zero_q, cout_q, ovf_q;

  logic              accept;
  logic              slice_y, slice_c;
  logic [DATA_W-1:0] fin_res;
  logic              fin_cout, fin_ovf;

  alu_bit_slice u_slice (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .y_o    (slice_y),
    .cout_o (slice_c)
  );

  assign accept = (state_q == ST_IDLE) && bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (fin_q)         state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Result formatting happens on the cycle after bit 31, giving the 33-cycle latency
  always_comb begin
    fin_cout = is_arith(op_q) ? carry_q : 1'b0;
    fin_ovf  = is_arith(op_q) ? (c31_q ^ carry_q) : 1'b0;
    fin_res  = (op_q == OP_SLT) ? {{(DATA_W-1){1'b0}}, sh_q[DATA_W-1] ^ fin_ovf} : sh_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c31_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      sh_q    <= '0;
      op_q    <= bus.op;
      cnt_q   <= '0;
      carry_q <= bus.op[2];
      fin_q   <= 1'b0;
    end else if (state_q == ST_RUN && !fin_q) begin
      a_q     <= {1'b0, a_q[DATA_W-1:1]};
      b_q     <= {1'b0, b_q[DATA_W-1:1]};
      sh_q    <= {slice_y, sh_q[DATA_W-1:1]};
      carry_q <= slice_c;
      cnt_q   <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        fin_q <= 1'b1;
        c31_q <= carry_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state_q == ST_RUN && fin_q) begin
      result_q <= fin_res;
      zero_q   <= (fin_res == '0);
      cout_q   <= fin_cout;
      ovf_q    <= fin_ovf;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - scoreboard bench for serial_alu_seq
module tb_serial_alu_seq;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   bp_hold = 1'b0;
  bit   seen = 1'b0;
  logic [34:0] snap;
  exp_t exp_q[$];

  serial_alu_seq_if bus ();

  serial_alu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    logic [32:0] s;
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.acc = 0;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'b100, 3'b110, 3'b111: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.c = s[32];
        e.v = (a[31] != b[31]) && (s[31] != a[31]);
        e.res = (op == 3'b111) ? {31'b0, $signed(a) < $signed(b)} : s[31:0];
      end
      default: ;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic push(input exp_t e);
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic issue_e(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input exp_t e);
    int tries = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.op = op;
    while (!bus.in_ready && tries < 300) begin
      @(negedge clk);
      tries++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    push(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    issue_e(a, b, op, model(a, b, op));
  endtask

  task automatic issue_k(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] r, input logic z, input logic c, input logic v);
    exp_t e;
    e.res = r; e.z = z; e.c = c; e.v = v; e.acc = 0;
    issue_e(a, b, op, e);
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && bus.in_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || !bus.in_ready) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Consumer backpressure
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
      if (!seen) begin
        seen = 1'b1;
        snap = {bus.result, bus.zero, bus.cout, bus.overflow};
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result",   bus.result,          e.res);
          chk("zero",     32'(bus.zero),       32'(e.z));
          chk("cout",     32'(bus.cout),       32'(e.c));
          chk("overflow", 32'(bus.overflow),   32'(e.v));
          chk("latency",  32'(cyc - e.acc),    32'd33);
        end
      end else begin
        chk("hold_stable", {29'd0, ({bus.result, bus.zero, bus.cout, bus.overflow} == snap)}, 32'd1);
      end
      if (bus.out_ready) seen = 1'b0;
    end
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    bus.result,         32'd0);
    chk("rst_flags",     {29'd0, bus.zero, bus.cout, bus.overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    issue_k(32'h0000_0005, 32'h0000_0003, 3'b010, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    issue_k(32'h8000_0000, 32'h0000_0001, 3'b110, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    issue_k(32'h8000_0000, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
    issue_k(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b100, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    issue_k(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    issue_k(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    issue_k(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    issue_k(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drain();

    // Backpressure with stray in_valid pulses, then a request on the DONE handshake edge
    bp_hold = 1'b1;
    issue_k(32'h0000_0005, 32'h0000_0007, 3'b110, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
    chk("bp_reach_done", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.a = $urandom; bus.b = $urandom; bus.op = 3'b010;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_still_valid", 32'(bus.out_valid), 32'd1);
    bp_hold = 1'b0;
    n = 0;
    while (!(bus.out_valid && bus.out_ready) && n < 60) begin @(negedge clk); n++; end
    bus.in_valid = 1'b1; bus.a = 32'd10; bus.b = 32'd20; bus.op = 3'b010;
    @(posedge clk);
    #1;
    chk("no_accept_on_done_edge", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    push(model(32'd10, 32'd20, 3'b010));
    bus.in_valid = 1'b0;
    drain();

    // Abort mid-run
    issue(32'h1234_5678, 32'h1111_1111, 3'b010);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue_k(32'd1, 32'd1, 3'b010, 32'd2, 1'b0, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = rnd_word();
      rb = ($urandom_range(0, 5) == 0) ? ra : rnd_word();
      issue(ra, rb, 3'($urandom_range(0, 7)));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all other ports are listed below.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/opcode offer
- in_ready  output  1  block can accept an operation
- a  input  32  operand A
- b  input  32  operand B
- op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 100 BEQ, 110 SUB, 111 SLT; 011 and 101 unused
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  32  operation result
- zero  output  1  result == 0
- cout  output  1  final carry out of bit 31 (arithmetic ops)
- overflow  output  1  signed overflow (ADD/SUB/BEQ/SLT)

Function
REQ-002 The block SHALL perform one 32-bit operation bit-serially, LSB first, through a single 1-bit ALU slice, one bit per clock.
REQ-003 The FSM SHALL have states IDLE, RUN and DONE; IDLE->RUN on in_valid&&in_ready; RUN->DONE after bit 31 is processed; DONE->IDLE on out_valid&&out_ready.
REQ-004 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-005 On accept, the block SHALL capture a, b and op into internal shift and op registers, clear the 5-bit bit counter, and preload carry = 1 for op[2]=1 (SUB/BEQ/SLT), else 0.
REQ-006 Each RUN cycle, the slice SHALL compute from a[i], b[i] (inverted when op[2]=1) and carry, register its carry for bit i+1, and shift its bit into result[i].
REQ-007 Latency SHALL be 33 cycles: accept at edge T gives out_valid high after edge T+33.
REQ-008 AND/OR SHALL produce bitwise a&b / a|b; ADD SHALL produce a+b mod 2^32; SUB and BEQ SHALL produce a-b mod 2^32.
REQ-009 SLT SHALL produce result = {31'b0, s}, where s = sum[31] XOR overflow of a-b (signed compare).
REQ-010 Opcodes 011 and 101 SHALL produce result = 0, cout = 0, overflow = 0, and still take 33 cycles.
REQ-011 zero SHALL equal (result == 0) for every opcode; for BEQ it is the branch-taken flag.
REQ-012 overflow SHALL equal carry-into-bit-31 XOR carry-out-of-bit-31 for arithmetic ops, else 0; cout SHALL be the bit-31 carry-out for arithmetic ops, else 0.
REQ-013 result, zero, cout and overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 in_valid during RUN or DONE SHALL be ignored; the operation is not queued.
REQ-015 The same edge that completes the DONE handshake SHALL NOT accept a new operation; the earliest new accept is the next edge, from IDLE.

Reset
REQ-016 Asserting rst SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, result=0, zero=0, cout=0, overflow=0, counter=0, carry=0.
REQ-017 Reset asserted during RUN or DONE SHALL abort the operation and produce no out_valid for it.

Structure
REQ-018 The opcode constants (OP_AND, OP_OR, OP_ADD, OP_BEQ, OP_SUB, OP_SLT) and the FSM state encoding SHALL live in the shared package alu_pkg.
REQ-019 The per-bit datapath SHALL be the sub-module alu_bit_slice, which is combinational, uses a full adder plus a B-invert mux, and is instantiated once.
REQ-020 The sequencing, counter and shift registers SHALL reside in serial_alu_seq.

Verification
REQ-021 ADD a=0x0000_0005, b=0x0000_0003 -> out_valid exactly 33 cycles after accept, result=0x0000_0008, zero=0, cout=0, overflow=0.
REQ-022 SUB a=0x8000_0000, b=0x0000_0001 -> result=0x7FFF_FFFF, overflow=1, cout=1; SLT with the same operands -> result=0x0000_0001.
REQ-023 BEQ a=b=0xDEAD_BEEF -> result=0, zero=1; AND 0xF0F0_F0F0 & 0x0FF0_0FF0 -> 0x00F0_00F0; OR of the same operands -> 0xFFF0_FFF0.
REQ-024 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; in_valid pulses meanwhile are ignored.
REQ-025 Reset at RUN cycle 15 -> IDLE, no out_valid; a following ADD 1+1 returns 2.
REQ-026 Opcode 011 with a=b=0xFFFF_FFFF -> result=0, zero=1, latency 33 cycles.
